fm_mod_matrix_accum: RTL and testbench



---
 rtl/fm_mod_matrix_accum_pkg.sv | 26 ++
 rtl/fm_mod_matrix_accum_if.sv | 30 +++
 rtl/fm_mod_matrix_accum_mult.sv | 22 ++
 rtl/fm_mod_matrix_accum.sv | 147 ++++++++++++++
 tb/tb_fm_mod_matrix_accum.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fm_mod_matrix_accum_pkg.sv
// Shared types and constants for the FM operator modulation-matrix accumulator.
package fm_pkg;

   localparam int unsigned OP_CNT    = 4;
   localparam logic [15:0] SAT16     = 16'hFFFF;
   localparam int unsigned TAG_IDX_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   // Travels beside each operand pair through the multiplier latency
   typedef struct packed {
      logic                 valid;
      logic                 first;
      logic                 last;
      logic [TAG_IDX_W-1:0] idx;
   } tag_t;

   function automatic int unsigned acc_width(input int unsigned n);
      return 32 + $clog2(n);
   endfunction

endpackage

// File: rtl/fm_mod_matrix_accum_if.sv
// Request / coefficient-RAM / result bundle of the modulation-matrix accumulator.
interface fm_mod_matrix_accum_if
   import fm_pkg::*;
#(
   parameter int unsigned N_OP = OP_CNT
);
   localparam int unsigned IW  = (N_OP > 1) ? $clog2(N_OP) : 1;
   localparam int unsigned CAW = (N_OP > 1) ? $clog2(N_OP * N_OP) : 1;

   logic                  start;
   logic [N_OP-1:0][15:0] op_level;
   logic [CAW-1:0]        coef_addr;
   logic [15:0]           coef_data;
   logic                  busy;
   logic                  mod_valid;
   logic [IW-1:0]         mod_idx;
   logic [15:0]           mod_out;
   logic                  done;

   modport master (
      output start, op_level, coef_data,
      input  coef_addr, busy, mod_valid, mod_idx, mod_out, done
   );

   modport slave (
      input  start, op_level, coef_data,
      output coef_addr, busy, mod_valid, mod_idx, mod_out, done
   );

endinterface

// File: rtl/fm_mod_matrix_accum_mult.sv
// Pipelined 16x16 unsigned multiplier; product appears LATENCY cycles after the operands.
module unsigned_mult16 #(
   parameter int unsigned LATENCY = 3
) (
   input  logic        clk,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   logic [31:0] pipe [LATENCY];

   always_ff @(posedge clk) begin
      pipe[0] <= 32'(a) * 32'(b);
      for (int unsigned s = 1; s < LATENCY; s++) begin
         pipe[s] <= pipe[s-1];
      end
   end

   assign p = pipe[LATENCY-1];

endmodule

// File: rtl/fm_mod_matrix_accum.sv
// Streams coef[i][j]*level[j] through the multiplier and emits one saturated
// row sum per destination operator per pass.
module fm_mod_matrix_accum
   import fm_pkg::*;
#(
   parameter int unsigned N_OP     = OP_CNT,
   parameter int unsigned MULT_LAT = 3
) (
   input logic                  clk,
   input logic                  reset,
   fm_mod_matrix_accum_if.slave bus
);

   localparam int unsigned IW  = (N_OP > 1) ? $clog2(N_OP) : 1;
   localparam int unsigned CAW = (N_OP > 1) ? $clog2(N_OP * N_OP) : 1;
   localparam int unsigned AW  = acc_width(N_OP);

   state_t                state;
   logic [IW-1:0]         i_cnt;
   logic [IW-1:0]         j_cnt;
   logic [N_OP-1:0][15:0] level_q;
   logic [CAW-1:0]        coef_addr_q;
   logic                  busy_q;
   logic                  mod_valid_q;
   logic [IW-1:0]         mod_idx_q;
   logic [15:0]           mod_out_q;
   logic                  done_q;

   tag_t                  op_tag;
   logic [IW-1:0]         op_j;
   tag_t                  tag_pipe [MULT_LAT];
   tag_t                  tag_out;

   logic [15:0]           mult_b;
   logic [31:0]           product;
   logic [AW-1:0]         acc;
   logic [AW-1:0]         acc_sum;
   logic [AW-1:0]         row_shr;
   logic [15:0]           row_sat;

   // Operand stage: coef_data arrives one cycle after its address, so the
   // level index is delayed by the same register as the tag.
   assign mult_b  = level_q[op_j];
   assign tag_out = tag_pipe[MULT_LAT-1];

   unsigned_mult16 #(
      .LATENCY(MULT_LAT)
   ) u_mult (
      .clk (clk),
      .a   (bus.coef_data),
      .b   (mult_b),
      .p   (product)
   );

   always_comb begin
      acc_sum = (tag_out.first ? '0 : acc) + AW'(product);
      row_shr = acc_sum >> 16;
      row_sat = (row_shr > AW'(SAT16)) ? SAT16 : row_shr[15:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         i_cnt       <= '0;
         j_cnt       <= '0;
         level_q     <= '0;
         coef_addr_q <= '0;
         busy_q      <= 1'b0;
         op_tag      <= '0;
         op_j        <= '0;
         acc         <= '0;
         mod_valid_q <= 1'b0;
         mod_idx_q   <= '0;
         mod_out_q   <= '0;
         done_q      <= 1'b0;
         for (int unsigned s = 0; s < MULT_LAT; s++) begin
            tag_pipe[s] <= '0;
         end
      end else begin
         mod_valid_q <= 1'b0;
         done_q      <= 1'b0;
         op_tag      <= '0;

         case (state)
            IDLE: begin
               if (bus.start) begin
                  level_q     <= bus.op_level;
                  i_cnt       <= '0;
                  j_cnt       <= '0;
                  coef_addr_q <= '0;
                  busy_q      <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               op_tag <= '{valid: 1'b1,
                          first: (j_cnt == '0),
                          last:  (j_cnt == IW'(N_OP - 1)),
                          idx:   TAG_IDX_W'(i_cnt)};
               op_j   <= j_cnt;
               if (j_cnt == IW'(N_OP - 1)) begin
                  j_cnt <= '0;
                  if (i_cnt == IW'(N_OP - 1)) begin
                     state <= DRAIN;
                  end else begin
                     i_cnt       <= i_cnt + IW'(1);
                     coef_addr_q <= coef_addr_q + CAW'(1);
                  end
               end else begin
                  j_cnt       <= j_cnt + IW'(1);
                  coef_addr_q <= coef_addr_q + CAW'(1);
               end
            end
            DRAIN: begin
               if (done_q) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         tag_pipe[0] <= op_tag;
         for (int unsigned s = 1; s < MULT_LAT; s++) begin
            tag_pipe[s] <= tag_pipe[s-1];
         end

         if (tag_out.valid) begin
            acc <= acc_sum;
            if (tag_out.last) begin
               mod_valid_q <= 1'b1;
               mod_idx_q   <= tag_out.idx[IW-1:0];
               mod_out_q   <= row_sat;
               done_q      <= (tag_out.idx == TAG_IDX_W'(N_OP - 1));
            end
         end
      end
   end

   assign bus.coef_addr = coef_addr_q;
   assign bus.busy      = busy_q;
   assign bus.mod_valid = mod_valid_q;
   assign bus.mod_idx   = mod_idx_q;
   assign bus.mod_out   = mod_out_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_fm_mod_matrix_accum.sv
// Directed bench for fm_mod_matrix_accum with a row-sum reference model and a
// per-cycle compare process.
module tb_fm_mod_matrix_accum;

   localparam int N = 4;
   localparam int L = 3;

   typedef struct {
      int          idx;
      logic [15:0] val;
      bit          last;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int   cyc        = 0;
   int   vectors    = 0;
   int   errors     = 0;
   int   busy_lo    = 1;
   int   busy_hi    = 0;
   int   free_cyc   = 0;
   int   mv_total   = 0;
   int   done_total = 0;
   bit   chk_en     = 1'b0;

   logic [15:0] coef_mem [N*N];
   exp_t        exp_tab [int];

   fm_mod_matrix_accum_if #(.N_OP(N)) bus ();

   fm_mod_matrix_accum #(
      .N_OP     (N),
      .MULT_LAT (L)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous coefficient RAM: data one cycle after address
   always @(posedge clk) bus.coef_data <= coef_mem[bus.coef_addr];

   function automatic longint row_sum(input int i, input logic [N-1:0][15:0] lev);
      longint s = 0;
      for (int j = 0; j < N; j++) s += longint'(coef_mem[i*N+j]) * longint'(lev[j]);
      return s;
   endfunction

   function automatic logic [15:0] row_result(input int i, input logic [N-1:0][15:0] lev);
      longint r = row_sum(i, lev) >> 16;
      return (r > 65535) ? 16'hFFFF : r[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: schedule a pass's results from levels seen at acceptance
   always @(posedge clk) begin
      if (reset) begin
         exp_tab.delete();
         busy_lo  = 1;
         busy_hi  = 0;
         free_cyc = 0;
      end else if (bus.start === 1'b1 && cyc >= free_cyc) begin
         for (int i = 0; i < N; i++) begin
            exp_tab[cyc + 3 + i*N + N - 1 + L] = '{i, row_result(i, bus.op_level), (i == N-1)};
         end
         busy_lo  = cyc + 1;
         busy_hi  = cyc + 2 + N*N + L;
         free_cyc = busy_hi + 1;
      end
      cyc++;
   end

   always @(negedge clk) begin : compare
      exp_t e;
      if (chk_en) begin
         if (exp_tab.exists(cyc)) begin
            e = exp_tab[cyc];
            chk("mod_valid", 32'(bus.mod_valid), 32'd1);
            chk("mod_idx", 32'(bus.mod_idx), 32'(e.idx));
            chk("mod_out", 32'(bus.mod_out), 32'(e.val));
            chk("done", 32'(bus.done), 32'(e.last));
         end else begin
            chk("mod_valid_idle", 32'(bus.mod_valid), 32'd0);
            chk("done_idle", 32'(bus.done), 32'd0);
         end
         chk("busy", 32'(bus.busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
         if (bus.mod_valid === 1'b1) mv_total++;
         if (bus.done === 1'b1) done_total++;
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic run_pass(output int k);
      @(negedge clk);
      bus.start = 1'b1;
      k = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int k, input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         errors++;
         $display("FAIL %s: done not seen within 40 cycles of start at %0d", name, k);
      end else begin
         chk(name, 32'(cyc), 32'(k + 2 + N*N + L));
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_mod_valid"}, 32'(bus.mod_valid), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_mod_out"}, 32'(bus.mod_out), 32'd0);
      chk({tag, "_mod_idx"}, 32'(bus.mod_idx), 32'd0);
      chk({tag, "_coef_addr"}, 32'(bus.coef_addr), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0][15:0] lev;
      logic [N-1:0][15:0] lev_mix;
      int k, mv0, d0;

      bus.start    = 1'b0;
      bus.op_level = '0;
      for (int a = 0; a < N*N; a++) coef_mem[a] = '0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_all_zero("reset");
      chk_en = 1'b1;

      // Identity row: only coef[0][1] set
      coef_mem[1] = 16'hFFFF;
      lev[0] = 16'h1234; lev[1] = 16'h8000; lev[2] = 16'hFFFF; lev[3] = 16'h0042;
      chk("pin_identity_r0", 32'(row_result(0, lev)), 32'h7FFF);
      chk("pin_identity_r1", 32'(row_result(1, lev)), 32'h0000);
      bus.op_level = lev;
      run_pass(k);
      wait_until(k + 9);
      chk("identity_r0_valid", 32'(bus.mod_valid), 32'd1);
      chk("identity_r0_out", 32'(bus.mod_out), 32'h7FFF);
      wait_done(k, "identity_done_cycle");
      @(negedge clk);
      chk("identity_busy_low", 32'(bus.busy), 32'd0);

      // Saturation: every term at full scale
      for (int a = 0; a < N*N; a++) coef_mem[a] = 16'hFFFF;
      lev = '1;
      chk("pin_sat_sum", 32'(row_sum(0, lev) >> 16), 32'h0003_FFF8);
      chk("pin_sat_val", 32'(row_result(3, lev)), 32'hFFFF);
      bus.op_level = lev;
      run_pass(k);
      wait_done(k, "sat_done_cycle");
      chk("sat_last_out", 32'(bus.mod_out), 32'hFFFF);
      chk("sat_last_idx", 32'(bus.mod_idx), 32'd3);

      // Exact sum on row 2, levels overwritten mid-pass
      coef_mem[0]  = 16'h1000; coef_mem[1]  = 16'h2000; coef_mem[2]  = 16'h3000; coef_mem[3]  = 16'h4000;
      coef_mem[4]  = 16'hFFFF; coef_mem[5]  = 16'h0000; coef_mem[6]  = 16'hFFFF; coef_mem[7]  = 16'h0000;
      coef_mem[8]  = 16'h4000; coef_mem[9]  = 16'h4000; coef_mem[10] = 16'h0000; coef_mem[11] = 16'h0000;
      coef_mem[12] = 16'h0001; coef_mem[13] = 16'h8000; coef_mem[14] = 16'h0100; coef_mem[15] = 16'hC000;
      lev_mix[0] = 16'h8000; lev_mix[1] = 16'h8000; lev_mix[2] = 16'h5555; lev_mix[3] = 16'hAAAA;
      chk("pin_exact_r2", 32'(row_result(2, lev_mix)), 32'h4000);
      chk("pin_exact_r0", 32'(row_result(0, lev_mix)), 32'h52AA);
      bus.op_level = lev_mix;
      run_pass(k);
      wait_until(k + 3);
      bus.op_level = '1;
      wait_until(k + 17);
      chk("exact_r2_valid", 32'(bus.mod_valid), 32'd1);
      chk("exact_r2_idx", 32'(bus.mod_idx), 32'd2);
      chk("exact_r2_out", 32'(bus.mod_out), 32'h4000);
      wait_done(k, "exact_done_cycle");

      // Starts while busy, including on the done cycle, are dropped
      bus.op_level = lev_mix;
      repeat (2) @(negedge clk);
      mv0 = mv_total;
      d0  = done_total;
      run_pass(k);
      wait_until(k + 5);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_until(k + 21);
      chk("busy_test_done_strobe", 32'(bus.done), 32'd1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_test_low_k22", 32'(bus.busy), 32'd0);
      repeat (25) @(negedge clk);
      chk("busy_test_valid_count", 32'(mv_total - mv0), 32'd4);
      chk("busy_test_done_count", 32'(done_total - d0), 32'd1);

      // Reset mid-pass, then a clean pass
      run_pass(k);
      wait_until(k + 10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_all_zero("midreset");
      mv0 = mv_total;
      d0  = done_total;
      repeat (20) @(negedge clk);
      chk("midreset_no_valid", 32'(mv_total - mv0), 32'd0);
      chk("midreset_no_done", 32'(done_total - d0), 32'd0);
      run_pass(k);
      wait_done(k, "post_reset_done_cycle");
      chk("post_reset_last_out", 32'(bus.mod_out), 32'(row_result(3, lev_mix)));

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
